cacheline_arbiter: RTL and testbench
====================================

# cacheline_arbiter

Shares one cacheline adaptor (256-bit line, 32-bit word memory port) between the L1 instruction cache and the L1 data cache of the multicycle OTTER. Each cache issues whole-line read or write requests. The arbiter grants one requester at a time, round-robin on contention, and latches the request onto the adaptor's cache-side port. It returns line data and a one-cycle valid pulse to the winner, and flags a sticky error if the adaptor never completes.

## Interface
- `TIMEOUT`, 1024: max cycles a granted transfer may wait for `ad_valid` before abort; legal range 2..65535.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `ic_read` in 1: I-cache line read request; held high until `ic_valid` is seen.
- `ic_addr` in 32: I-cache line address.
- `ic_rdata` out 256: line returned to I-cache.
- `ic_valid` out 1: one-cycle completion pulse to I-cache.
- `dc_read` / `dc_write` in 1 each: D-cache line read / writeback request; held until `dc_valid`.
- `dc_addr` in 32: D-cache line address.
- `dc_wdata` in 256: writeback line.
- `dc_rdata` out 256: line returned to D-cache.
- `dc_valid` out 1: one-cycle completion pulse to D-cache.
- `ad_read` / `ad_write` out 1 each: to adaptor `cache_read` / `cache_write`.
- `ad_addr` out 32, `ad_wdata` out 256: to adaptor `cache_addr` / `cache_wdata`.
- `ad_rdata` in 256, `ad_valid` in 1: from adaptor `cache_rdata` / `cache_valid`.
- `timeout_err` out 1: sticky, set on any aborted transfer; cleared only by reset.

## Operation
- States: IDLE, GNT_I, GNT_D, RESP.
- IDLE:
  - Samples the request lines.
  - If only I is pending, goes to GNT_I. If only D is pending, goes to GNT_D.
  - If both are pending, grants the requester not recorded in `last_gnt`.
  - On a grant: latches addr and wdata into internal registers, records the op (D-cache: `dc_write` wins if `dc_read` and `dc_write` are both high), updates `last_gnt`, and clears the watchdog counter.
- GNT_x:
  - `ad_read` or `ad_write` is driven high per the latched op. `ad_addr` and `ad_wdata` come from the latches, not live inputs.
  - Watchdog increments each cycle.
  - On `ad_valid`: captures `ad_rdata` into the winner's rdata register (reads only) and goes to RESP.
  - If the watchdog reaches `TIMEOUT-1` without `ad_valid`: sets `timeout_err`, leaves rdata unchanged, and goes to RESP.
- RESP:
  - `ad_read` and `ad_write` are low, so the adaptor can return to its idle state.
  - Winner's valid is high for exactly this cycle. No arbitration in this state.
  - Next state is IDLE.
- The loser's request stays pending, untouched, until the next IDLE. On writes, `dc_rdata` holds its previous value.
- `ic_rdata` and `dc_rdata` are separate registers. Each holds its value until that requester's next completed read.
- `last_gnt` encoding: 0 = I, 1 = D.

## Timing
- Reset (async, while `rst`=0):
  - State IDLE, `last_gnt`=0, watchdog 0.
  - All outputs 0: both valids, `ad_read`, `ad_write`, `ad_addr`, `ad_wdata`, both rdata registers, `timeout_err`.
  - Reset mid-transfer abandons it. No valid is ever issued for it.
- Cycle-level sequence:
  - Request seen high at edge 0 in IDLE.
  - Adaptor request high from cycle 1 (GNT).
  - `ad_valid` high in cycle N, sampled at edge N+1.
  - Upstream valid and rdata present in cycle N+1 (RESP).
  - IDLE in cycle N+2. Minimum request-to-valid latency is 2 cycles (adaptor valid in cycle 1).
- Requester rules:
  - Must drop its request at the edge ending its valid cycle.
  - A request still high in IDLE after RESP is treated as a new request.
- Back-to-back contention: minimum gap from one RESP to the next GNT is one IDLE cycle.
- Timeout: abort is taken when the watchdog reaches `TIMEOUT-1`, giving RESP at cycle `TIMEOUT+1` after grant.
  - `ad_valid` arriving in the same cycle as the timeout completes normally (valid wins, no error).
- Request inputs are ignored outside IDLE. `ad_valid` is ignored outside GNT.

## Test plan
- Single I read: `ic_read`=1, `ic_addr`=0x0000_0100; adaptor returns `ad_rdata`=pattern A after 9 cycles -> `ad_read`=1 with `ad_addr`=0x100 from cycle 1; `ic_valid` one cycle with `ic_rdata`=A; `dc_valid` never high.
- Simultaneous I read and D write after reset -> D is granted first (`ad_write`=1, `ad_wdata`=`dc_wdata` latched at grant); after `dc_valid`, I is granted; a third simultaneous pair grants D again. Alternation is verified over 8 rounds.
- Address change while granted: change `dc_addr` and `dc_wdata` mid-transfer -> `ad_addr` and `ad_wdata` stay at the latched values.
- Timeout: `TIMEOUT`=16, adaptor never valid -> RESP at cycle 17, `dc_valid` pulses, `timeout_err`=1 and stays 1, `dc_rdata` unchanged. Second case: `ad_valid` at the timeout cycle gives no error.
- Reset mid-transfer: `rst`=0 in cycle 4 of a D read -> all outputs 0 immediately, no `dc_valid`; after release, a new I request gets the first grant only if D is idle.
- `dc_read` and `dc_write` both high -> write is performed; `dc_rdata` unchanged.

Source files
------------

// File: rtl/cacheline_arbiter_if.sv
// rtl/cacheline_arbiter_if.sv - bundled I-cache, D-cache and adaptor signals for the line arbiter
// slave is the arbiter's view; master is the caches-plus-adaptor side.
interface cacheline_arbiter_if;
  logic         ic_read;
  logic [31:0]  ic_addr;
  logic [255:0] ic_rdata;
  logic         ic_valid;

  logic         dc_read;
  logic         dc_write;
  logic [31:0]  dc_addr;
  logic [255:0] dc_wdata;
  logic [255:0] dc_rdata;
  logic         dc_valid;

  logic         ad_read;
  logic         ad_write;
  logic [31:0]  ad_addr;
  logic [255:0] ad_wdata;
  logic [255:0] ad_rdata;
  logic         ad_valid;

  logic         timeout_err;

  modport slave (
    input  ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, ad_rdata, ad_valid,
    output ic_rdata, ic_valid, dc_rdata, dc_valid, ad_read, ad_write, ad_addr, ad_wdata,
           timeout_err
  );

  modport master (
    output ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, ad_rdata, ad_valid,
    input  ic_rdata, ic_valid, dc_rdata, dc_valid, ad_read, ad_write, ad_addr, ad_wdata,
           timeout_err
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - round-robin share of one cacheline adaptor between I-cache and D-cache
// One whole-line transfer at a time; a watchdog aborts transfers the adaptor never completes.
module cacheline_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic         last_gnt_q, last_gnt_d;   // 0 = I, 1 = D; also names the current winner
  logic         write_q, write_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wdata_q, wdata_d;
  logic [255:0] ic_rdata_q, ic_rdata_d;
  logic [255:0] dc_rdata_q, dc_rdata_d;
  logic [15:0]  wd_q, wd_d;
  logic         err_q, err_d;

  logic         i_req, d_req, pick_d, granted;

  assign i_req   = bus.ic_read;
  assign d_req   = bus.dc_read | bus.dc_write;
  assign granted = (state_q == GNT_I) || (state_q == GNT_D);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    wd_d       = wd_q;
    err_d      = err_q;
    pick_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // On contention the requester that did not win last time goes first.
          pick_d     = d_req && (!i_req || !last_gnt_q);
          state_d    = pick_d ? GNT_D : GNT_I;
          last_gnt_d = pick_d;
          write_d    = pick_d && bus.dc_write;
          addr_d     = pick_d ? bus.dc_addr : bus.ic_addr;
          if (pick_d) wdata_d = bus.dc_wdata;
          wd_d       = '0;
        end
      end
      GNT_I, GNT_D: begin
        wd_d = wd_q + 16'd1;
        if (bus.ad_valid) begin
          if (!write_q) begin
            if (state_q == GNT_I) ic_rdata_d = bus.ad_rdata;
            else                  dc_rdata_d = bus.ad_rdata;
          end
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
    end
  end

  assign bus.ad_read     = granted && !write_q;
  assign bus.ad_write    = granted && write_q;
  assign bus.ad_addr     = addr_q;
  assign bus.ad_wdata    = wdata_q;
  assign bus.ic_rdata    = ic_rdata_q;
  assign bus.dc_rdata    = dc_rdata_q;
  assign bus.ic_valid    = (state_q == RESP) && !last_gnt_q;
  assign bus.dc_valid    = (state_q == RESP) && last_gnt_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - directed self-checking bench for cacheline_arbiter
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_cacheline_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cacheline_arbiter_if bus();

  cacheline_arbiter #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_l(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called in grant cycle 1; raises ad_valid in cycle n, returns in the RESP cycle n+1.
  task automatic serve(input int n, input logic [255:0] data);
    logic early;
    early = 1'b0;
    for (int c = 1; c < n; c++) begin
      step();
      early = early | bus.ic_valid | bus.dc_valid;
    end
    bus.ad_valid = 1'b1;
    bus.ad_rdata = data;
    step();
    bus.ad_valid = 1'b0;
    bus.ad_rdata = '0;
    chk_b("early_valid", early, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_b({tag, "_ic_valid"}, bus.ic_valid, 1'b0);
    chk_b({tag, "_dc_valid"}, bus.dc_valid, 1'b0);
    chk_b({tag, "_ad_read"},  bus.ad_read,  1'b0);
    chk_b({tag, "_ad_write"}, bus.ad_write, 1'b0);
    chk_a({tag, "_ad_addr"},  bus.ad_addr,  32'h0);
    chk_l({tag, "_ad_wdata"}, bus.ad_wdata, '0);
    chk_l({tag, "_ic_rdata"}, bus.ic_rdata, '0);
    chk_l({tag, "_dc_rdata"}, bus.dc_rdata, '0);
    chk_b({tag, "_err"},      bus.timeout_err, 1'b0);
  endtask

  initial begin
    logic         d;
    logic [31:0]  exp_addr;
    logic [255:0] exp_wd, rd;
    logic [255:0] pat_a, pat_b, pat_c, pat_e, pat_w;
    logic         seen;

    pat_a = {8{32'hA5A5_0001}};
    pat_b = {8{32'hB0B0_0002}};
    pat_c = {8{32'hCC33_0003}};
    pat_e = {8{32'hE0E0_0005}};
    pat_w = {8{32'h5700_0000}};

    bus.ic_read = 0; bus.ic_addr = 0;
    bus.dc_read = 0; bus.dc_write = 0; bus.dc_addr = 0; bus.dc_wdata = '0;
    bus.ad_rdata = '0; bus.ad_valid = 0;

    // Reset state
    step(); step();
    check_reset_outputs("rst");
    rst = 1'b1;
    step();

    // Single I read, adaptor valid in cycle 9
    bus.ic_read = 1; bus.ic_addr = 32'h0000_0100;
    step();
    chk_b("i1_ad_read", bus.ad_read, 1'b1);
    chk_b("i1_ad_write", bus.ad_write, 1'b0);
    chk_a("i1_ad_addr", bus.ad_addr, 32'h0000_0100);
    serve(9, pat_a);
    chk_b("i1_ic_valid", bus.ic_valid, 1'b1);
    chk_b("i1_dc_valid", bus.dc_valid, 1'b0);
    chk_l("i1_ic_rdata", bus.ic_rdata, pat_a);
    chk_b("i1_resp_ad_read", bus.ad_read, 1'b0);
    bus.ic_read = 0;
    step();
    chk_b("i1_idle_ic_valid", bus.ic_valid, 1'b0);
    chk_b("i1_idle_ad_read", bus.ad_read, 1'b0);

    // Round-robin over 8 contended rounds, starting from reset
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.ic_read = 1; bus.ic_addr = 32'h0000_1000;
    bus.dc_write = 1; bus.dc_addr = 32'h0000_2000; bus.dc_wdata = pat_w;
    for (int r = 0; r < 8; r++) begin
      d        = (r % 2 == 0);
      exp_addr = d ? bus.dc_addr : bus.ic_addr;
      exp_wd   = bus.dc_wdata;
      rd       = {8{32'hC0DE_0000 | 32'(r)}};
      step();
      chk_b("rr_ad_write", bus.ad_write, d);
      chk_b("rr_ad_read", bus.ad_read, !d);
      chk_a("rr_ad_addr", bus.ad_addr, exp_addr);
      if (d) begin
        chk_l("rr_ad_wdata", bus.ad_wdata, exp_wd);
        bus.dc_addr  = ~exp_addr;
        bus.dc_wdata = ~exp_wd;
      end
      serve(3, rd);
      chk_b("rr_ic_valid", bus.ic_valid, !d);
      chk_b("rr_dc_valid", bus.dc_valid, d);
      chk_a("rr_addr_held", bus.ad_addr, exp_addr);
      if (d) begin
        chk_l("rr_wdata_held", bus.ad_wdata, exp_wd);
        chk_l("rr_dc_rdata_kept", bus.dc_rdata, '0);
        bus.dc_write = 0;
      end else begin
        chk_l("rr_ic_rdata", bus.ic_rdata, rd);
        bus.ic_read = 0;
      end
      step();
      chk_b("rr_idle_valid", bus.ic_valid | bus.dc_valid, 1'b0);
      chk_b("rr_idle_ad", bus.ad_read | bus.ad_write, 1'b0);
      if (d) begin
        bus.dc_write = 1;
        bus.dc_addr  = 32'h0000_2000 + 32'(r) * 32'h40;
        bus.dc_wdata = pat_w | 256'(r);
      end else begin
        bus.ic_read = 1;
        bus.ic_addr = 32'h0000_1000 + 32'(r) * 32'h40;
      end
    end
    bus.ic_read = 0; bus.dc_write = 0;
    step();

    // D read, then read+write together performs the write with minimum latency
    bus.dc_read = 1; bus.dc_addr = 32'h0000_3000;
    step();
    chk_b("dr_ad_read", bus.ad_read, 1'b1);
    serve(2, pat_b);
    chk_b("dr_dc_valid", bus.dc_valid, 1'b1);
    chk_l("dr_dc_rdata", bus.dc_rdata, pat_b);
    bus.dc_read = 0;
    step();
    bus.dc_read = 1; bus.dc_write = 1; bus.dc_addr = 32'h0000_3040; bus.dc_wdata = pat_e;
    step();
    chk_b("rw_ad_write", bus.ad_write, 1'b1);
    chk_b("rw_ad_read", bus.ad_read, 1'b0);
    chk_l("rw_ad_wdata", bus.ad_wdata, pat_e);
    serve(1, pat_c);
    chk_b("rw_dc_valid", bus.dc_valid, 1'b1);
    chk_l("rw_dc_rdata_kept", bus.dc_rdata, pat_b);
    bus.dc_read = 0; bus.dc_write = 0;
    step();

    // ad_valid in the watchdog's last cycle completes normally
    bus.dc_read = 1; bus.dc_addr = 32'h0000_4000;
    step();
    serve(16, pat_e);
    chk_b("tv_dc_valid", bus.dc_valid, 1'b1);
    chk_l("tv_dc_rdata", bus.dc_rdata, pat_e);
    chk_b("tv_no_err", bus.timeout_err, 1'b0);
    bus.dc_read = 0;
    step();

    // Adaptor never answers: abort lands RESP in cycle 17
    bus.dc_read = 1; bus.dc_addr = 32'h0000_5000;
    step();
    seen = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      step();
      seen = seen | bus.dc_valid | bus.timeout_err;
    end
    chk_b("to_quiet_before", seen, 1'b0);
    chk_b("to_c16_ad_read", bus.ad_read, 1'b1);
    step();
    chk_b("to_dc_valid", bus.dc_valid, 1'b1);
    chk_b("to_err", bus.timeout_err, 1'b1);
    chk_l("to_dc_rdata_kept", bus.dc_rdata, pat_e);
    bus.dc_read = 0;
    step();
    step();
    chk_b("to_err_sticky", bus.timeout_err, 1'b1);
    chk_b("to_idle_valid", bus.dc_valid, 1'b0);

    // Reset in cycle 4 of a D read abandons it
    bus.dc_read = 1; bus.dc_addr = 32'h0000_6000;
    step(); step(); step(); step();
    chk_b("mr_c4_ad_read", bus.ad_read, 1'b1);
    rst = 1'b0;
    bus.dc_read = 0;
    #1;
    check_reset_outputs("mr");
    step();
    step();
    rst = 1'b1;
    bus.ic_read = 1; bus.ic_addr = 32'h0000_0200;
    seen = 1'b0;
    step();
    chk_b("mr_i_ad_read", bus.ad_read, 1'b1);
    chk_a("mr_i_ad_addr", bus.ad_addr, 32'h0000_0200);
    seen = seen | bus.dc_valid;
    serve(2, pat_c);
    seen = seen | bus.dc_valid;
    chk_b("mr_ic_valid", bus.ic_valid, 1'b1);
    chk_l("mr_ic_rdata", bus.ic_rdata, pat_c);
    bus.ic_read = 0;
    step();
    seen = seen | bus.dc_valid;
    chk_b("mr_no_dc_valid", seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
